result_collector: RTL and testbench
===================================

RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter CHANNELS, default 4: number of hash-lane inputs, 1..16.
REQ-002 Parameter DATA_BITS, default 32: result word width, 1..64.
REQ-003 Parameter META_BITS, default 12: per-result tag width.
REQ-004 Parameter DEPTH, default 16: FIFO entries, power of two, >=2.
REQ-005 Derived CW = max(1, clog2(CHANNELS)); word width W = CW+META_BITS+DATA_BITS.
REQ-006 clk  in  1  single clock; all logic posedge clk.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 in_valid  in  CHANNELS  per-lane result valid, one-cycle qualifier.
REQ-009 in_data  in  CHANNELS*DATA_BITS  lane i at bits [i*DATA_BITS +: DATA_BITS].
REQ-010 in_meta  in  CHANNELS*META_BITS  lane i tag, same packing.
REQ-011 mask_bits  in  7  count of MSBs of in_data that must be zero for a match, 0..DATA_BITS; larger values clamp to DATA_BITS.
REQ-012 capture_all  in  1  1 = every valid result qualifies; 0 = match only.
REQ-013 out_req  in  1  pop-and-serialise request.
REQ-014 out_bit  out  1  serial data, LSB first.
REQ-015 out_busy  out  1  serialiser shifting.
REQ-016 out_empty  out  1  FIFO empty.
REQ-017 drop_count  out  16  saturating count of discarded results.

Function
REQ-018 Lane qualifies in cycle t when in_valid[i] and (capture_all or top mask_bits of in_data lane i all zero); mask_bits=0 qualifies every valid result.
REQ-019 Each lane has a one-entry pending register; a qualifying result is registered at t+1 as {lane index, meta, data}.
REQ-020 Qualifying result on a lane whose pending entry stays occupied after this cycle's grant SHALL be dropped (pending keeps the older entry) and increment drop_count.
REQ-021 Arbiter: round-robin over occupied pending entries, one grant per cycle, search starting at lane after last grant; grant clears pending same edge.
REQ-022 Granted entry written to FIFO at grant edge; earliest write t+2, out_empty low from t+2 after that edge.
REQ-023 FIFO full: no grant issued, pending entries held (further arrivals drop per REQ-020).
REQ-024 Pending register may be granted and reloaded in the same edge without drop.
REQ-025 FIFO pointers are clog2(DEPTH)+1 bits, wrap naturally; full/empty from pointer compare.
REQ-026 out_req sampled high with out_empty=0 and out_busy=0 pops head; next cycle shift register = head, out_bit = bit 0, out_busy=1.
REQ-027 Shift right each cycle, zero fill; out_busy high exactly W cycles; bit k of word on out_bit k cycles after load.
REQ-028 out_req while out_busy or out_empty SHALL be ignored; FIFO write and pop in same cycle both take effect.
REQ-029 drop_count saturates at 16'hFFFF.

Reset
REQ-030 rst high at an edge: FIFO pointers, pending valids, arbiter pointer (lane 0 next), shift register, drop_count cleared; out_bit=0, out_busy=0, out_empty=1 following that edge.
REQ-031 Reset mid-serialisation aborts the word; in-flight inputs in rst cycle are discarded.

Verification
REQ-032 CHANNELS=4, mask_bits=8, lane 2 in_data=32'h00ABCDEF meta=12'h123 -> out_empty low 2 cycles later; serialised 46-bit word {2'd2,12'h123,32'h00ABCDEF} LSB first.
REQ-033 Same, in_data=32'h01000000 -> no FIFO write, out_empty stays 1; capture_all=1 -> written.
REQ-034 All 4 lanes qualify in one cycle -> FIFO order lanes 0,1,2,3; next simultaneous burst starts at lane 0 again after lane 3 grant.
REQ-035 Fill FIFO to DEPTH with no pops, then 3 more qualifying results on lane 1 -> one held pending, drop_count=2, out_empty never set, pop order intact.
REQ-036 out_req pulsed during busy -> ignored; pulsed after 46 cycles -> next word.
REQ-037 rst asserted mid-word -> out_busy=0, out_empty=1, drop_count=0 next cycle.

Source files
------------

// File: rtl/result_collector.sv
// Collects qualifying results from parallel hash lanes into a FIFO through
// per-lane pending registers and a round-robin arbiter, then serialises words LSB first.
module result_collector #(
  parameter int CHANNELS  = 4,
  parameter int DATA_BITS = 32,
  parameter int META_BITS = 12,
  parameter int DEPTH     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS-1:0]             in_valid,
  input  logic [CHANNELS*DATA_BITS-1:0]   in_data,
  input  logic [CHANNELS*META_BITS-1:0]   in_meta,
  input  logic [6:0]                      mask_bits,
  input  logic                            capture_all,
  input  logic                            out_req,
  output logic                            out_bit,
  output logic                            out_busy,
  output logic                            out_empty,
  output logic [15:0]                     drop_count
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int W  = CW + META_BITS + DATA_BITS;
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(W + 1);
  localparam int DW = $clog2(CHANNELS + 1);
  localparam int unsigned NCH = CHANNELS;
  localparam int unsigned NDB = DATA_BITS;

  logic [6:0]          mask_eff;
  logic [CHANNELS-1:0] top_zero;
  logic [CHANNELS-1:0] qual;
  logic [CHANNELS-1:0] pend_v;
  logic [W-1:0]        pend_w [CHANNELS];
  logic [CW-1:0]       rr_ptr;
  logic [CW-1:0]       gnt_idx;
  logic                gnt_valid;
  logic [CHANNELS-1:0] gnt_hot;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] drop;
  logic [DW-1:0]       drop_n;
  logic [16:0]         drop_sum;
  int unsigned         arb_idx;

  logic [W-1:0]        mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                full;
  logic                empty;
  logic                pop;

  logic [W-1:0]        shreg;
  logic [NW-1:0]       left;

  assign mask_eff = (mask_bits > 7'(DATA_BITS)) ? 7'(DATA_BITS) : mask_bits;

  // A data bit falls inside the masked MSB window when b >= DATA_BITS - mask_eff.
  always_comb begin
    top_zero = '1;
    for (int unsigned i = 0; i < NCH; i++) begin
      for (int unsigned b = 0; b < NDB; b++) begin
        if ((b + 32'(mask_eff)) >= NDB && in_data[i*NDB + b])
          top_zero[i] = 1'b0;
      end
    end
    qual = in_valid & (top_zero | {CHANNELS{capture_all}});
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    arb_idx   = 0;
    for (int unsigned off = 0; off < NCH; off++) begin
      arb_idx = 32'(rr_ptr) + off;
      if (arb_idx >= NCH)
        arb_idx = arb_idx - NCH;
      if (!gnt_valid && pend_v[arb_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CW'(arb_idx);
      end
    end
    if (full)
      gnt_valid = 1'b0;
  end

  // A lane granted this edge frees its slot, so a new arrival reloads it without a drop.
  always_comb begin
    gnt_hot = '0;
    load    = '0;
    drop    = '0;
    drop_n  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      gnt_hot[i] = gnt_valid && (gnt_idx == CW'(i));
      load[i]    = qual[i] && (!pend_v[i] || gnt_hot[i]);
      drop[i]    = qual[i] && pend_v[i] && !gnt_hot[i];
      drop_n     = drop_n + DW'(drop[i]);
    end
    drop_sum = {1'b0, drop_count} + 17'(drop_n);
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = out_req && !empty && !out_busy;

  assign out_busy  = (left != '0);
  assign out_bit   = shreg[0];
  assign out_empty = empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v     <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      shreg      <= '0;
      left       <= '0;
      drop_count <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (load[i])
          pend_v[i] <= 1'b1;
        else if (gnt_hot[i])
          pend_v[i] <= 1'b0;
      end
      if (gnt_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gnt_idx == CW'(CHANNELS - 1)) ? '0 : gnt_idx + CW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        shreg  <= mem[rd_ptr[AW-1:0]];
        left   <= NW'(W);
      end else if (out_busy) begin
        shreg  <= shreg >> 1;
        left   <= left - 1'b1;
      end
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (load[i])
        pend_w[i] <= {CW'(i), in_meta[i*META_BITS +: META_BITS], in_data[i*DATA_BITS +: DATA_BITS]};
    end
    if (gnt_valid)
      mem[wr_ptr[AW-1:0]] <= pend_w[gnt_idx];
  end

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed scenarios plus randomized traffic checked
// against a queue-based reference model advanced once per clock edge.
module tb_result_collector;

  localparam int CH  = 4;
  localparam int DB  = 32;
  localparam int MB  = 12;
  localparam int DEP = 16;
  localparam int WW  = 46;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   in_valid;
  logic [CH*DB-1:0] in_data;
  logic [CH*MB-1:0] in_meta;
  logic [6:0]      mask_bits;
  logic            capture_all;
  logic            out_req;
  logic            out_bit;
  logic            out_busy;
  logic            out_empty;
  logic [15:0]     drop_count;

  int total = 0;
  int bad   = 0;

  // Reference model state (value after the most recent edge).
  bit                m_pv [CH];
  longint unsigned   m_pw [CH];
  int                m_last;
  longint unsigned   m_fifo [$];
  int                m_drops;
  longint unsigned   m_sh;
  int                m_left;

  result_collector #(.CHANNELS(CH), .DATA_BITS(DB), .META_BITS(MB), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_meta(in_meta),
    .mask_bits(mask_bits), .capture_all(capture_all), .out_req(out_req),
    .out_bit(out_bit), .out_busy(out_busy), .out_empty(out_empty), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned mkword(int lane, logic [MB-1:0] meta, logic [DB-1:0] d);
    return (longint'(lane) << (MB + DB)) | (longint'(meta) << DB) | longint'(d);
  endfunction

  function automatic bit qualifies(bit v, logic [DB-1:0] d, int mask, bit ca);
    int m;
    m = (mask > DB) ? DB : mask;
    if (!v) return 1'b0;
    if (ca || m == 0) return 1'b1;
    return (d >> (DB - m)) == 0;
  endfunction

  task automatic model_update();
    bit full, busy, pop, q;
    int g, l;
    longint unsigned popped;
    if (rst) begin
      foreach (m_pv[i]) m_pv[i] = 1'b0;
      m_last = CH - 1;
      m_fifo.delete();
      m_drops = 0;
      m_sh = 0;
      m_left = 0;
      return;
    end
    full = (m_fifo.size() == DEP);
    busy = (m_left > 0);
    pop  = out_req && (m_fifo.size() != 0) && !busy;
    g = -1;
    if (!full)
      for (int k = 1; k <= CH; k++) begin
        l = (m_last + k) % CH;
        if (g < 0 && m_pv[l]) g = l;
      end
    popped = 0;
    if (pop) popped = m_fifo.pop_front();
    if (g >= 0) begin
      m_fifo.push_back(m_pw[g]);
      m_pv[g] = 1'b0;
      m_last = g;
    end
    for (int i = 0; i < CH; i++) begin
      q = qualifies(in_valid[i], in_data[i*DB +: DB], int'(mask_bits), capture_all);
      if (q) begin
        if (m_pv[i]) m_drops = (m_drops >= 65535) ? 65535 : m_drops + 1;
        else begin
          m_pv[i] = 1'b1;
          m_pw[i] = mkword(i, in_meta[i*MB +: MB], in_data[i*DB +: DB]);
        end
      end
    end
    if (pop) begin
      m_sh = popped;
      m_left = WW;
    end else if (m_left > 0) begin
      m_sh = m_sh >> 1;
      m_left--;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = '0;
    in_data = '0;
    in_meta = '0;
    out_req = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic read_word(output logic [WW-1:0] w, output int nb);
    out_req = 1'b1;
    step();
    out_req = 1'b0;
    nb = 0;
    w = '0;
    for (int k = 0; k < WW; k++) begin
      w[k] = out_bit;
      nb += int'(out_busy);
      step();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    mask_bits = 7'd0;
    capture_all = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (out_bit !== 1'b0) begin bad++; $display("FAIL reset_out_bit got=%b exp=0", out_bit); end
    total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", out_busy); end
    total++; if (out_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", out_empty); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drops got=%0d exp=0", drop_count); end
  endtask

  task automatic test_match();
    logic [WW-1:0] w, exp;
    int nb;
    do_reset();
    exp = {2'd2, 12'h123, 32'h00ABCDEF};
    mask_bits = 7'd8;
    capture_all = 1'b0;
    in_valid = 4'b0100;
    in_data[2*DB +: DB] = 32'h00ABCDEF;
    in_meta[2*MB +: MB] = 12'h123;
    step();
    clear_inputs();
    total++; if (out_empty !== 1'b1) begin bad++; $display("FAIL match_empty_t1 got=%b exp=1", out_empty); end
    step();
    total++; if (out_empty !== 1'b0) begin bad++; $display("FAIL match_empty_t2 got=%b exp=0", out_empty); end
    read_word(w, nb);
    total++; if (w !== exp) begin bad++; $display("FAIL match_word got=%h exp=%h", w, exp); end
    total++; if (nb !== WW) begin bad++; $display("FAIL match_busy_len got=%0d exp=%0d", nb, WW); end
    total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL match_busy_end got=%b exp=0", out_busy); end
    total++; if (out_empty !== 1'b1) begin bad++; $display("FAIL match_empty_end got=%b exp=1", out_empty); end
  endtask

  task automatic test_nomatch();
    logic [WW-1:0] w, exp;
    int nb;
    do_reset();
    mask_bits = 7'd8;
    capture_all = 1'b0;
    in_valid = 4'b0100;
    in_data[2*DB +: DB] = 32'h01000000;
    in_meta[2*MB +: MB] = 12'h123;
    step();
    clear_inputs();
    step();
    step();
    total++; if (out_empty !== 1'b1) begin bad++; $display("FAIL nomatch_empty got=%b exp=1", out_empty); end
    capture_all = 1'b1;
    in_valid = 4'b0100;
    in_data[2*DB +: DB] = 32'h01000000;
    in_meta[2*MB +: MB] = 12'h123;
    step();
    clear_inputs();
    step();
    total++; if (out_empty !== 1'b0) begin bad++; $display("FAIL capall_empty got=%b exp=0", out_empty); end
    exp = {2'd2, 12'h123, 32'h01000000};
    read_word(w, nb);
    total++; if (w !== exp) begin bad++; $display("FAIL capall_word got=%h exp=%h", w, exp); end
    capture_all = 1'b0;
  endtask

  task automatic test_order();
    logic [WW-1:0] w;
    int nb;
    do_reset();
    mask_bits = 7'd0;
    capture_all = 1'b1;
    for (int burst = 0; burst < 2; burst++) begin
      in_valid = 4'hF;
      for (int i = 0; i < CH; i++) begin
        in_data[i*DB +: DB] = 32'(100 + 10*burst + i);
        in_meta[i*MB +: MB] = 12'(i + 1);
      end
      step();
      clear_inputs();
      for (int k = 0; k < 5; k++) step();
      for (int i = 0; i < CH; i++) begin
        read_word(w, nb);
        total++;
        if (w[45:44] !== 2'(i) || w[31:0] !== 32'(100 + 10*burst + i)) begin
          bad++;
          $display("FAIL order_b%0d_%0d got=%h exp_lane=%0d exp_data=%0d", burst, i, w, i, 100 + 10*burst + i);
        end
      end
    end
    capture_all = 1'b0;
  endtask

  task automatic test_full();
    logic [WW-1:0] w;
    int nb;
    bit saw_empty;
    do_reset();
    mask_bits = 7'd0;
    capture_all = 1'b1;
    saw_empty = 1'b0;
    for (int n = 0; n < DEP; n++) begin
      in_valid = 4'b0001;
      in_data[0 +: DB] = 32'(n);
      step();
    end
    clear_inputs();
    step();
    step();
    for (int n = 0; n < 3; n++) begin
      in_valid = 4'b0010;
      in_data[DB +: DB] = 32'hA0 + 32'(n);
      step();
      if (out_empty) saw_empty = 1'b1;
    end
    clear_inputs();
    step();
    total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL full_drops got=%0d exp=2", drop_count); end
    total++; if (saw_empty || out_empty !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", saw_empty | out_empty); end
    for (int n = 0; n < DEP; n++) begin
      read_word(w, nb);
      total++; if (w[31:0] !== 32'(n)) begin bad++; $display("FAIL full_pop_%0d got=%h exp=%0d", n, w[31:0], n); end
    end
    read_word(w, nb);
    total++; if (w !== {2'd1, 12'h0, 32'hA0}) begin bad++; $display("FAIL full_held got=%h exp=%h", w, {2'd1, 12'h0, 32'hA0}); end
    total++; if (out_empty !== 1'b1) begin bad++; $display("FAIL full_drain got=%b exp=1", out_empty); end
    capture_all = 1'b0;
  endtask

  task automatic test_ignore();
    logic [WW-1:0] w;
    int nb;
    do_reset();
    mask_bits = 7'd0;
    capture_all = 1'b1;
    in_valid = 4'b0001;
    in_data[0 +: DB] = 32'h11;
    step();
    clear_inputs();
    in_valid = 4'b1000;
    in_data[3*DB +: DB] = 32'h22;
    step();
    clear_inputs();
    step();
    step();
    out_req = 1'b1;
    step();
    nb = 0;
    w = '0;
    for (int k = 0; k < 50; k++) begin
      out_req = (k == 10);
      if (k < WW) w[k] = out_bit;
      nb += int'(out_busy);
      step();
    end
    out_req = 1'b0;
    total++; if (nb !== WW) begin bad++; $display("FAIL ignore_busy_len got=%0d exp=%0d", nb, WW); end
    total++; if (w !== {2'd0, 12'h0, 32'h11}) begin bad++; $display("FAIL ignore_word1 got=%h exp=%h", w, {2'd0, 12'h0, 32'h11}); end
    total++; if (out_empty !== 1'b0) begin bad++; $display("FAIL ignore_kept got=%b exp=0", out_empty); end
    read_word(w, nb);
    total++; if (w !== {2'd3, 12'h0, 32'h22}) begin bad++; $display("FAIL ignore_word2 got=%h exp=%h", w, {2'd3, 12'h0, 32'h22}); end
    capture_all = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mask_bits = 7'd0;
    capture_all = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_valid = 4'b0100;
      in_data[2*DB +: DB] = 32'hFFFF_FFFF;
      step();
    end
    clear_inputs();
    step();
    out_req = 1'b1;
    step();
    out_req = 1'b0;
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1;
    in_valid = 4'hF;
    in_data = '1;
    step();
    rst = 1'b0;
    clear_inputs();
    total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", out_busy); end
    total++; if (out_empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty got=%b exp=1", out_empty); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL rstmid_drops got=%0d exp=0", drop_count); end
    total++; if (out_bit !== 1'b0) begin bad++; $display("FAIL rstmid_bit got=%b exp=0", out_bit); end
    step();
    step();
    total++; if (out_empty !== 1'b1) begin bad++; $display("FAIL rstmid_discard got=%b exp=1", out_empty); end
    capture_all = 1'b0;
  endtask

  task automatic test_random();
    int lbad;
    lbad = 0;
    do_reset();
    for (int c = 0; c < 4000 && lbad < 20; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      out_req = ($urandom_range(0, 3) == 0);
      capture_all = ($urandom_range(0, 7) == 0);
      mask_bits = 7'($urandom_range(0, 40));
      for (int i = 0; i < CH; i++) begin
        in_valid[i] = ($urandom_range(0, 2) == 0);
        in_data[i*DB +: DB] = $urandom >> $urandom_range(0, 32);
        in_meta[i*MB +: MB] = 12'($urandom);
      end
      step();
      total++; if (out_bit !== m_sh[0]) begin bad++; lbad++; $display("FAIL rnd_bit c=%0d got=%b exp=%b", c, out_bit, m_sh[0]); end
      total++; if (out_busy !== (m_left > 0)) begin bad++; lbad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, out_busy, m_left > 0); end
      total++; if (out_empty !== (m_fifo.size() == 0)) begin bad++; lbad++; $display("FAIL rnd_empty c=%0d got=%b exp=%b", c, out_empty, m_fifo.size() == 0); end
      total++; if (drop_count !== 16'(m_drops)) begin bad++; lbad++; $display("FAIL rnd_drops c=%0d got=%0d exp=%0d", c, drop_count, m_drops); end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    mask_bits = 7'd0;
    capture_all = 1'b0;
    test_reset();
    test_match();
    test_nomatch();
    test_order();
    test_full();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
